// File: rtl/wishbone_management_bridge_pkg.sv
// rtl/wishbone_management_bridge_pkg.sv - shared types and constants for the management bridge
// Purpose: FSM state encoding, management bus widths, wait counter width and
//          the read pattern returned on a timed-out access.
// Ports:   none (package).
package wishbone_management_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_ACK     = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam int WB_ADDR_W     = 24;
  localparam int MGMT_ADDR_W   = 20;
  localparam int MGMT_DATA_W   = 32;
  localparam int TIMEOUT_CNT_W = 16;

  localparam logic [MGMT_DATA_W-1:0] ERROR_READ_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/wishbone_management_bridge_if.sv
// rtl/wishbone_management_bridge_if.sv - Wishbone slave and management bus signal bundle
// Purpose: groups the Wishbone pipelined slave signals and the core
//          management bus request/response signals seen by the bridge.
// Modports:
//   slave  - bridge view: Wishbone requests and management responses in,
//            Wishbone responses and management requests out.
//   master - environment view (interconnect plus management block), reversed.
interface wishbone_management_bridge_if;
  import wishbone_management_bridge_pkg::*;

  logic                   wb_cyc_i;
  logic                   wb_stb_i;
  logic                   wb_we_i;
  logic [3:0]             wb_sel_i;
  logic [WB_ADDR_W-1:0]   wb_adr_i;
  logic [MGMT_DATA_W-1:0] wb_data_i;
  logic                   wb_ack_o;
  logic                   wb_stall_o;
  logic                   wb_error_o;
  logic [MGMT_DATA_W-1:0] wb_data_o;

  logic                   wb_management_writeEnable;
  logic                   wb_management_readEnable;
  logic [3:0]             wb_management_byteSelect;
  logic [MGMT_ADDR_W-1:0] wb_management_address;
  logic [MGMT_DATA_W-1:0] wb_management_writeData;
  logic [MGMT_DATA_W-1:0] wb_management_readData;
  logic                   wb_management_busy;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output wb_ack_o, wb_stall_o, wb_error_o, wb_data_o,
    output wb_management_writeEnable, wb_management_readEnable,
    output wb_management_byteSelect, wb_management_address, wb_management_writeData,
    input  wb_management_readData, wb_management_busy
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input  wb_ack_o, wb_stall_o, wb_error_o, wb_data_o,
    input  wb_management_writeEnable, wb_management_readEnable,
    input  wb_management_byteSelect, wb_management_address, wb_management_writeData,
    output wb_management_readData, wb_management_busy
  );

endinterface

// File: rtl/wishbone_management_bridge.sv
// rtl/wishbone_management_bridge.sv - Wishbone B4 pipelined slave driving the core management bus
// Purpose: turns each selected Wishbone cycle into one held management request,
//          waits while the management block is busy (JTAG owns it), registers
//          read data and returns a single-cycle ack.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - wishbone_management_bridge_if.slave (Wishbone slave + management master)
// Parameters:
//   BASE_ADDRESS   - wb_adr_i[23:20] value that selects this bridge
//   TIMEOUT_CYCLES - busy-stalled cycles before an error response (2..65535)
// Build option: MANAGEMENT_BRIDGE_TIMEOUT_EN enables the wait counter and the
//   ERROR response; without it a request waits on busy indefinitely.
module wishbone_management_bridge
  import wishbone_management_bridge_pkg::*;
#(
  parameter logic [3:0] BASE_ADDRESS   = 4'h3,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  wishbone_management_bridge_if.slave  bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

  state_t                 state;
  state_t                 state_next;
  logic                   we_q;
  logic [3:0]             sel_q;
  logic [MGMT_ADDR_W-1:0] adr_q;
  logic [MGMT_DATA_W-1:0] wdata_q;
  logic [MGMT_DATA_W-1:0] rdata_q;
  logic                   hit;
  logic                   in_request;

  assign hit = bus.wb_cyc_i & bus.wb_stb_i &
               (bus.wb_adr_i[WB_ADDR_W-1:MGMT_ADDR_W] == BASE_ADDRESS);
  assign in_request = (state == ST_REQUEST);

`ifdef MANAGEMENT_BRIDGE_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[TIMEOUT_CNT_W-1:0];

  logic [TIMEOUT_CNT_W-1:0] wait_cnt;

  // Clearing while idle is enough: REQUEST is only ever entered from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else if (in_request && bus.wb_management_busy &&
                 wait_cnt != {TIMEOUT_CNT_W{1'b1}}) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (hit) state_next = ST_REQUEST;
      end
      ST_REQUEST: begin
        // A completed access whose cycle was withdrawn gets no ack.
        if (!bus.wb_management_busy) begin
          state_next = bus.wb_cyc_i ? ST_ACK : ST_IDLE;
        end else if (!bus.wb_cyc_i) begin
          state_next = ST_IDLE;
`ifdef MANAGEMENT_BRIDGE_TIMEOUT_EN
        end else if (wait_cnt >= TIMEOUT_LIMIT) begin
          state_next = ST_ERROR;
`endif
        end
      end
      ST_ACK:   state_next = ST_IDLE;
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && hit) begin
        we_q    <= bus.wb_we_i;
        sel_q   <= bus.wb_sel_i;
        adr_q   <= bus.wb_adr_i[MGMT_ADDR_W-1:0];
        wdata_q <= bus.wb_data_i;
      end
      if (in_request && !bus.wb_management_busy) begin
        rdata_q <= we_q ? '0 : bus.wb_management_readData;
      end else if (in_request && state_next == ST_ERROR) begin
        rdata_q <= ERROR_READ_DATA;
      end
    end
  end

  assign bus.wb_stall_o = (state != ST_IDLE);
  assign bus.wb_ack_o   = (state == ST_ACK);
`ifdef MANAGEMENT_BRIDGE_TIMEOUT_EN
  assign bus.wb_error_o = (state == ST_ERROR);
`else
  assign bus.wb_error_o = 1'b0;
`endif
  assign bus.wb_data_o  = rdata_q;

  assign bus.wb_management_writeEnable = in_request & we_q;
  assign bus.wb_management_readEnable  = in_request & ~we_q;
  assign bus.wb_management_byteSelect  = in_request ? sel_q   : '0;
  assign bus.wb_management_address     = in_request ? adr_q   : '0;
  assign bus.wb_management_writeData   = in_request ? wdata_q : '0;

endmodule

// File: tb/tb_wishbone_management_bridge.sv
// tb/tb_wishbone_management_bridge.sv - scoreboard bench for wishbone_management_bridge
module tb_wishbone_management_bridge;

  localparam int TO = 4;
`ifdef MANAGEMENT_BRIDGE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [19:0] adr;
    logic [31:0] data;
    int          dur;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  bit   mon_on = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   stall_q[$];

  wishbone_management_bridge_if bus();

  wishbone_management_bridge #(
    .BASE_ADDRESS  (4'h3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", nm, cycle);
  endtask

  function automatic logic [95:0] all_outputs();
    return {bus.wb_ack_o, bus.wb_stall_o, bus.wb_error_o, bus.wb_data_o,
            bus.wb_management_writeEnable, bus.wb_management_readEnable,
            bus.wb_management_byteSelect, bus.wb_management_address,
            bus.wb_management_writeData};
  endfunction

  // Monitor: pops expectations whenever the DUT presents a request, a stall
  // run or a response.
  logic en_now, en_prev = 1'b0;
  bit   cur_valid = 1'b0;
  req_t cur;
  int   en_len = 0;
  int   stall_len = 0;
  int   exp_stall;
  rsp_t s;

  always @(negedge clk) begin
    if (mon_on) begin
      en_now = bus.wb_management_writeEnable | bus.wb_management_readEnable;
      if (en_now) begin
        if (!en_prev) begin
          en_len = 0;
          if (req_q.size() == 0) begin
            cur_valid = 1'b0;
            unexpected("req_unexpected");
          end else begin
            cur = req_q.pop_front();
            cur_valid = 1'b1;
          end
        end
        en_len++;
        if (cur_valid)
          chk("req_fields",
              {bus.wb_management_writeEnable, bus.wb_management_readEnable,
               bus.wb_management_byteSelect, bus.wb_management_address,
               bus.wb_management_writeData},
              {cur.we, ~cur.we, cur.sel, cur.adr, cur.data});
      end else if (en_prev && cur_valid) begin
        chk("req_cycles", en_len, cur.dur);
      end
      en_prev = en_now;

      if (bus.wb_stall_o) begin
        stall_len++;
      end else if (stall_len > 0) begin
        if (stall_q.size() == 0) unexpected("stall_unexpected");
        else begin
          exp_stall = stall_q.pop_front();
          chk("stall_cycles", stall_len, exp_stall);
        end
        stall_len = 0;
      end

      if (bus.wb_ack_o || bus.wb_error_o) begin
        if (rsp_q.size() == 0) unexpected("rsp_unexpected");
        else begin
          s = rsp_q.pop_front();
          chk("rsp_kind", {bus.wb_ack_o, bus.wb_error_o}, s.err ? 2'b01 : 2'b10);
          chk("rsp_data", bus.wb_data_o, s.data);
          chk("rsp_cycle", cycle, s.cyc);
        end
      end
    end
  end

  // mode 0: normal cycle; mode 1: cyc dropped at REQUEST cycle k0;
  // mode 2: reset asserted at REQUEST cycle k0. b = busy cycles at start of REQUEST.
  task automatic xfer(input bit hit, input bit we, input logic [3:0] sel,
                      input logic [19:0] a, input logic [31:0] d, input logic [31:0] rd,
                      input int b, input int mode, input int k0);
    int   c, lim;
    bit   to;
    logic [3:0] nib;
    req_t r;
    rsp_t e;
    c = cycle;
    to = TIMEOUT_ON && (b > TO);
    nib = 4'h3;
    if (!hit) begin
      nib = 4'($urandom_range(0, 14));
      if (nib >= 4'h3) nib = nib + 4'h1;
    end
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = {nib, a};
    bus.wb_data_i = d;
    bus.wb_management_readData = rd;
    bus.wb_management_busy = 1'b0;
    if (!hit) lim = 2;
    else if (mode != 0) lim = k0;
    else if (to) lim = TO + 2;
    else lim = b + 2;
    if (hit) begin
      r.we = we; r.sel = sel; r.adr = a; r.data = d;
      if (mode != 0) begin
        r.dur = k0;
        stall_q.push_back(k0);
      end else if (to) begin
        r.dur = TO + 1;
        stall_q.push_back(TO + 2);
        e.err = 1'b1; e.data = 32'hFFFF_FFFF; e.cyc = c + TO + 2;
        rsp_q.push_back(e);
      end else begin
        r.dur = b + 1;
        stall_q.push_back(b + 2);
        e.err = 1'b0; e.data = we ? 32'h0 : rd; e.cyc = c + b + 2;
        rsp_q.push_back(e);
      end
      req_q.push_back(r);
    end
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      bus.wb_stb_i = 1'b0;
      bus.wb_management_busy = (k <= b);
    end
    bus.wb_cyc_i = 1'b0;
    if (mode == 2) begin
      rst = 1'b1;
      @(negedge clk);
      chk("reset_mid_outputs", all_outputs(), 96'h0);
      rst = 1'b0;
    end
    @(negedge clk);
    bus.wb_management_busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 24'h0;
    bus.wb_data_i = 32'h0;
    bus.wb_management_readData = 32'h0;
    bus.wb_management_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outputs(), 96'h0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    xfer(1, 1, 4'hF, 20'h00000, 32'h1, 32'h0, 0, 0, 0);
    xfer(1, 0, 4'hF, 20'h00004, 32'h0, 32'h0000_001A, 0, 0, 0);
    xfer(1, 0, 4'h3, 20'h00008, 32'h0, 32'hCAFE_0042, 5, 0, 0);
    xfer(0, 1, 4'hF, 20'h00000, 32'h5, 32'h0, 0, 0, 0);
`ifdef MANAGEMENT_BRIDGE_TIMEOUT_EN
    xfer(1, 0, 4'hF, 20'h00010, 32'h0, 32'h1234_5678, 100, 0, 0);
    xfer(1, 0, 4'hF, 20'h00014, 32'h0, 32'h0BAD_F00D, 0, 0, 0);
`endif
    xfer(1, 0, 4'hF, 20'h00020, 32'h0, 32'h1111_2222, 100, 1, 2);
    xfer(1, 1, 4'hC, 20'h00024, 32'h3333_4444, 32'h0, 100, 2, 3);
    xfer(1, 0, 4'hF, 20'h00028, 32'h0, 32'h5555_6666, 0, 1, 1);
    xfer(1, 1, 4'h1, 20'hABCDE, 32'h7777_8888, 32'h0, 1, 0, 0);

    for (int i = 0; i < 25; i++) begin
      xfer($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 20'($urandom), $urandom, $urandom,
           $urandom_range(0, 6), 0, 0);
    end

    repeat (4) @(negedge clk);
    chk("req_q_drained", req_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("stall_q_drained", stall_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
